// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, data-width limits and bit-order encoding for the UART RX slice.
package uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam int DW_MIN = 5;
  localparam int DW_MAX = 9;
  localparam logic LSB_FIRST = 1'b0;
  localparam logic MSB_FIRST = 1'b1;
endpackage

// File: rtl/uart_bit_shifter.sv
// uart_bit_shifter: directional shift register with clear; nxt exposes the value loaded on the next edge.
module uart_bit_shifter
  import uart_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         dir,
  input  logic         din,
  output logic [W-1:0] nxt
);
  logic [W-1:0] q;
  logic [W-1:0] base;
  // clear and shift may coincide so the first bit of a frame lands in a fresh register
  always_comb begin
    base = clr ? '0 : q;
    nxt  = !shift_en ? base : dir == MSB_FIRST ? {base[W-2:0], din} : {din, base[W-1:1]};
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else q <= nxt;
endmodule

// File: rtl/uart_rx_deser_param.sv
// uart_rx_deser_param: collects DATA_WIDTH sampled bits into P_DATA with a one-cycle data_valid pulse.
// Optional running parity on par_bit when DESER_PARITY_EN is defined; otherwise par_bit is 0.
module uart_rx_deser_param
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  localparam int CNT_W = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  deser_en,
  input  logic                  sample_stb,
  input  logic                  sampled_bit,
  input  logic                  msb_first,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  busy,
  output logic [CNT_W-1:0]      bit_idx,
  output logic                  par_bit
);
  if (DATA_WIDTH < DW_MIN || DATA_WIDTH > DW_MAX) begin : g_bad_width
    $error("DATA_WIDTH out of range");
  end
  state_t state;
  logic order_q;
  logic start, abort, take, last;
  logic [DATA_WIDTH-1:0] nxt;
  // a strobe coinciding with the enable rising edge is bit 0 of the frame
  assign start = state == IDLE && deser_en;
  assign abort = state == SHIFT && !deser_en;
  assign take  = sample_stb && deser_en && state != DONE;
  assign last  = state == SHIFT && take && bit_idx == CNT_W'(DATA_WIDTH - 1);
  uart_bit_shifter #(.W(DATA_WIDTH)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr      (start || abort),
    .shift_en (take),
    .dir      (state == IDLE ? msb_first : order_q),
    .din      (sampled_bit),
    .nxt      (nxt)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      order_q    <= LSB_FIRST;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      bit_idx    <= '0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE:
          if (deser_en) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            order_q <= msb_first;
            bit_idx <= take ? CNT_W'(1) : '0;
          end
        SHIFT:
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            bit_idx <= '0;
          end else if (take) begin
            bit_idx <= bit_idx + CNT_W'(1);
            if (last) begin
              state      <= DONE;
              busy       <= 1'b0;
              P_DATA     <= nxt;
              data_valid <= 1'b1;
            end
          end
        DONE:
          if (!deser_en) begin
            state   <= IDLE;
            bit_idx <= '0;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef DESER_PARITY_EN
  logic par_run;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      par_run <= 1'b0;
      par_bit <= 1'b0;
    end else begin
      if (start) par_run <= take & sampled_bit;
      else if (take) par_run <= par_run ^ sampled_bit;
      if (last) par_bit <= par_run ^ sampled_bit;
    end
`else
  assign par_bit = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_deser_param.sv
// tb_uart_rx_deser_param: directed frames against 5/8/9-bit builds with hand-computed words and parity.
module tb_uart_rx_deser_param;
`ifdef DESER_PARITY_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif
  logic clk = 0, rst = 0, deser_en = 0, sample_stb = 0, sampled_bit = 0, msb_first = 0;
  logic [7:0] p8;
  logic [4:0] p5;
  logic [8:0] p9;
  logic [3:0] idx8, idx9;
  logic [2:0] idx5;
  logic dv8, dv5, dv9, busy8, busy5, busy9, par8, par5, par9;
  int n_cmp = 0, n_bad = 0, dv_cnt = 0;
  always #5 clk = ~clk;
  uart_rx_deser_param #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .deser_en(deser_en), .sample_stb(sample_stb), .sampled_bit(sampled_bit),
    .msb_first(msb_first), .P_DATA(p8), .data_valid(dv8), .busy(busy8), .bit_idx(idx8), .par_bit(par8));
  uart_rx_deser_param #(.DATA_WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .deser_en(deser_en), .sample_stb(sample_stb), .sampled_bit(sampled_bit),
    .msb_first(msb_first), .P_DATA(p5), .data_valid(dv5), .busy(busy5), .bit_idx(idx5), .par_bit(par5));
  uart_rx_deser_param #(.DATA_WIDTH(9)) dut9 (
    .clk(clk), .rst(rst), .deser_en(deser_en), .sample_stb(sample_stb), .sampled_bit(sampled_bit),
    .msb_first(msb_first), .P_DATA(p9), .data_valid(dv9), .busy(busy9), .bit_idx(idx9), .par_bit(par9));
  always @(posedge dv8) dv_cnt++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic open_frame(input logic msb);
    deser_en = 1;
    msb_first = msb;
    @(negedge clk);
    chk("open_busy", 32'(busy8), 1);
    chk("open_idx", 32'(idx8), 0);
  endtask
  task automatic close_frame();
    deser_en = 0;
    @(negedge clk);
    chk("close_busy", 32'(busy8), 0);
    chk("close_idx", 32'(idx8), 0);
  endtask
  // bits[i] is the i-th bit on the wire; strobes are single-cycle with one idle cycle between
  task automatic frame(input string tag, input logic [7:0] bits, input int s, input logic [7:0] exp, input logic ep);
    int c0;
    c0 = dv_cnt;
    for (int i = s; i < 8; i++) begin
      sample_stb = 1;
      sampled_bit = bits[i];
      @(negedge clk);
      sample_stb = 0;
      if (i == 2) chk({tag, "_mid_idx"}, 32'(idx8), 3);
      if (i == 2) chk({tag, "_mid_busy"}, 32'(busy8), 1);
      if (i == 7) begin
        chk({tag, "_dv"}, 32'(dv8), 1);
        chk({tag, "_data"}, 32'(p8), 32'(exp));
        chk({tag, "_idx"}, 32'(idx8), 8);
        chk({tag, "_par"}, 32'(par8), 32'(ep & PAR_ON));
      end
      @(negedge clk);
    end
    chk({tag, "_dv_drop"}, 32'(dv8), 0);
    chk({tag, "_dv_count"}, 32'(dv_cnt - c0), 1);
  endtask
  initial begin
    int c0;
    @(negedge clk);
    chk("rst_data", 32'(p8), 0);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_idx", 32'(idx8), 0);
    chk("rst_dv", 32'(dv8), 0);
    chk("rst_par", 32'(par8), 0);
    rst = 1;
    @(negedge clk);
    // LSB-first A5, even parity
    open_frame(0);
    frame("lsb_a5", 8'hA5, 0, 8'hA5, 1'b0);
    close_frame();
    // abort after 5 bits, with a strobe on the abort cycle
    open_frame(0);
    c0 = dv_cnt;
    for (int i = 0; i < 5; i++) begin
      sample_stb = 1; sampled_bit = 1; @(negedge clk); sample_stb = 0; @(negedge clk);
    end
    chk("abort_idx5", 32'(idx8), 5);
    deser_en = 0; sample_stb = 1; sampled_bit = 1;
    @(negedge clk);
    sample_stb = 0;
    chk("abort_busy", 32'(busy8), 0);
    chk("abort_idx", 32'(idx8), 0);
    chk("abort_hold", 32'(p8), 32'h00A5);
    chk("abort_no_dv", 32'(dv_cnt - c0), 0);
    open_frame(0);
    frame("lsb_3c", 8'h3C, 0, 8'h3C, 1'b0);
    close_frame();
    // MSB-first C1, bit 0 strobed in the same cycle as the enable rises
    deser_en = 1; msb_first = 1; sample_stb = 1; sampled_bit = 1;
    @(negedge clk);
    sample_stb = 0; msb_first = 0;
    chk("same_cyc_idx", 32'(idx8), 1);
    @(negedge clk);
    frame("msb_c1", 8'h83, 1, 8'hC1, 1'b1);
    // parity and stop strobes while DONE are ignored
    c0 = dv_cnt;
    for (int i = 0; i < 2; i++) begin
      sample_stb = 1; sampled_bit = 0; @(negedge clk); sample_stb = 0; @(negedge clk);
    end
    chk("done_hold", 32'(p8), 32'h00C1);
    chk("done_idx", 32'(idx8), 8);
    chk("done_no_dv", 32'(dv_cnt - c0), 0);
    chk("done_par", 32'(par8), 32'(PAR_ON));
    close_frame();
    // all-ones: 5/8/9-bit builds each finish at their own width
    open_frame(0);
    for (int i = 0; i < 9; i++) begin
      sample_stb = 1; sampled_bit = 1; @(negedge clk); sample_stb = 0; @(negedge clk);
    end
    chk("w5_data", 32'(p5), 32'h1F);
    chk("w5_idx", 32'(idx5), 5);
    chk("w5_par", 32'(par5), 32'(PAR_ON));
    chk("w8_data", 32'(p8), 32'hFF);
    chk("w8_par", 32'(par8), 0);
    chk("w9_data", 32'(p9), 32'h1FF);
    chk("w9_idx", 32'(idx9), 9);
    chk("w9_par", 32'(par9), 32'(PAR_ON));
    close_frame();
    // asynchronous reset mid-frame, re-entry with enable held high
    open_frame(0);
    for (int i = 0; i < 3; i++) begin
      sample_stb = 1; sampled_bit = 1; @(negedge clk); sample_stb = 0; @(negedge clk);
    end
    #2 rst = 0;
    #1;
    chk("arst_data", 32'(p8), 0);
    chk("arst_busy", 32'(busy8), 0);
    chk("arst_idx", 32'(idx8), 0);
    chk("arst_dv", 32'(dv8), 0);
    chk("arst_par", 32'(par8), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rearm_busy", 32'(busy8), 1);
    chk("rearm_idx", 32'(idx8), 0);
    frame("lsb_55", 8'h55, 0, 8'h55, 1'b0);
    close_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_deser_param.md
Name: uart_rx_deser_param

Overview:
Parametrised successor to the UART RX deserializer. Collects DATA_WIDTH serial bits, one per sample strobe from the RX sampler, into a parallel word. Supports run-time LSB-first or MSB-first order and reports completion with a one-cycle valid pulse. Sits in UART_RX between the data sampler / FSM and the parity/stop checkers. The last good word is held until the next word completes.

Parameters:
DATA_WIDTH, 8, frame data bits; legal range 5..9.
CNT_W, $clog2(DATA_WIDTH+1), width of the bit index (derived; do not override).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
deser_en  input  1  frame-active enable from the RX FSM; high for the whole data phase.
sample_stb  input  1  one-cycle pulse: sampled_bit is valid this cycle.
sampled_bit  input  1  majority-voted bit from the sampler.
msb_first  input  1  bit order; 0 = LSB first (UART default), 1 = MSB first.
P_DATA  output  DATA_WIDTH  assembled word; holds the last completed frame.
data_valid  output  1  one-cycle pulse when P_DATA updates.
busy  output  1  high in SHIFT.
bit_idx  output  CNT_W  bits collected in the current frame, 0..DATA_WIDTH.
par_bit  output  1  XOR of the bits of the last completed word (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous): P_DATA=0, data_valid=0, busy=0, bit_idx=0, par_bit=0, shift register=0, state=IDLE.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - deser_en=1 -> SHIFT. Clear the shift register and bit_idx. Latch msb_first into order_q for the whole frame.
  - A sample_stb in the same cycle as the IDLE->SHIFT transition is captured as bit 0. A 1-cycle-late enable must not drop bit 0.
- SHIFT, on each sample_stb:
  - LSB-first: sreg <= {sampled_bit, sreg[DATA_WIDTH-1:1]}.
  - MSB-first: sreg <= {sreg[DATA_WIDTH-2:0], sampled_bit}.
  - bit_idx increments.
- Completion: when the strobe lands with bit_idx == DATA_WIDTH-1:
  - Next cycle: P_DATA = completed word (including this bit), data_valid = 1 for exactly that cycle, bit_idx = DATA_WIDTH, state = DONE.
  - Latency: 1 clock from the final strobe edge.
- DONE:
  - Further sample_stb are ignored (parity/stop bits belong to other blocks). P_DATA, bit_idx and par_bit are held.
  - deser_en=0 -> IDLE, bit_idx=0.
- Abort: deser_en falls in SHIFT before completion (framing glitch, false start) -> IDLE next cycle.
  - Shift register cleared, no data_valid, P_DATA keeps the previous word.
- Simultaneous events: deser_en=0 with sample_stb in SHIFT -> abort wins and the bit is discarded.
- Back-to-back frames: deser_en dropping for a single cycle is sufficient to re-arm. The IDLE->SHIFT transition needs deser_en=1 again.
- sample_stb high for more than one cycle: each high cycle counts as one bit. Upstream guarantees single-cycle pulses.
- busy = (state==SHIFT), registered.

Optional Feature:
Macro DESER_PARITY_EN.
- Defined: a running XOR is updated with every captured bit and cleared on entry to SHIFT. par_bit is loaded with it on the same edge as P_DATA, so the parity checker compares directly against the received parity bit.
- Undefined: no XOR logic is built; par_bit is tied to 0.

Decomposition:
- Shared package uart_pkg: FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2), DATA_WIDTH min/max constants, the LSB_FIRST/MSB_FIRST encoding of msb_first.
- One natural sub-module, uart_bit_shifter: a parametrised shift register with a direction input and a clear input, instantiated once.
- FSM, counter and parity logic stay in the top.

Test Plan:
1. DATA_WIDTH=8, LSB-first: strobe bits 1,0,1,0,0,1,0,1 -> P_DATA=8'hA5, one data_valid pulse 1 clk after the 8th strobe, par_bit=0 (with DESER_PARITY_EN).
2. DATA_WIDTH=8, msb_first=1: same bit sequence -> P_DATA=8'hA5 bit-reversed = 8'hA5 check fails deliberately; use bits 1,1,0,0,0,0,0,1 -> P_DATA=8'hC1, par_bit=1.
3. Abort: 5 strobes, then deser_en=0 -> no data_valid, P_DATA keeps the prior 8'hA5; next full frame 8'h3C completes correctly.
4. DATA_WIDTH=5 and DATA_WIDTH=9 builds: all-ones frame -> P_DATA=5'h1F, par_bit=1 and 9'h1FF, par_bit=1; bit_idx ends at 5 and 9 respectively.
5. Extra strobes in DONE (parity + stop): 2 extra strobes -> P_DATA unchanged, no second data_valid.
6. Assert rst low mid-SHIFT (after 3 bits) -> all outputs 0 immediately (asynchronous). After release with deser_en held high, the FSM re-enters SHIFT and a fresh 8'h55 frame completes.
